ysyx_22040237_idu: RTL and testbench

Registered decode/issue stage for the single-cycle RV64 NPC core. It accepts a fetched instruction and PC over a valid/ready handshake, and reads the register file combinationally. It decodes the instruction and issues the EXU operand bundle (inst_opcode, op1, op2, op1_jump, op2_jump, inst_ebreak, invalid_inst) from an output register with a valid/ready handshake. After issuing ebreak or an invalid instruction it stops accepting fetch and halts.

---
 rtl/ysyx_22040237_idu_pkg.sv | 32 +++
 rtl/ysyx_22040237_imm_gen.sv | 23 ++
 rtl/ysyx_22040237_idu.sv | 210 +++++++++++++++++++++
 tb/tb_ysyx_22040237_idu.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040237_idu_pkg.sv
// ============================================================================
// Module      : ysyx_22040237_idu_pkg
// Description : Shared constants for the IDU: EXU opcodes, RV64 major opcodes,
//               the EBREAK word and the issue FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_22040237_idu_pkg;

  localparam logic [7:0] INST_NOP = 8'h00;
  localparam logic [7:0] INST_ADD = 8'h01;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] JAL    = 7'h6f;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [6:0] SYSTEM = 7'h73;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } idu_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_22040237_imm_gen.sv
// ============================================================================
// Module      : ysyx_22040237_imm_gen
// Description : Combinational I/U/J immediate extraction, sign-extended to XLEN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22040237_imm_gen #(
  parameter int XLEN = 64
) (
  input  logic [31:12]     inst,
  output logic [XLEN-1:0]  imm_i,
  output logic [XLEN-1:0]  imm_u,
  output logic [XLEN-1:0]  imm_j
);

  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_u = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

endmodule

`default_nettype wire

// File: rtl/ysyx_22040237_idu.sv
// ============================================================================
// Module      : ysyx_22040237_idu
// Description : Registered decode/issue stage; halts after issuing ebreak or an
//               invalid instruction. Optional perf counters: YSYX_22040237_IDU_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22040237_idu
  import ysyx_22040237_idu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int OPC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [31:0]       in_inst,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPC_W-1:0]  inst_opcode,
  output logic [XLEN-1:0]   op1,
  output logic [XLEN-1:0]   op2,
  output logic [XLEN-1:0]   op1_jump,
  output logic [XLEN-1:0]   op2_jump,
  output logic              jump,
  output logic [4:0]        rd_addr,
  output logic              rd_wen,
  output logic [XLEN-1:0]   out_pc,
  output logic              inst_ebreak,
  output logic              invalid_inst,
  output logic              halted
`ifdef YSYX_22040237_IDU_PERF_EN
  ,
  output logic [63:0]       perf_issued,
  output logic [63:0]       perf_stall
`endif
);

  idu_state_e r_state, w_state_nxt;

  logic              r_out_valid;
  logic [OPC_W-1:0]  r_opcode;
  logic [XLEN-1:0]   r_op1, r_op2, r_op1_jump, r_op2_jump, r_pc;
  logic              r_jump, r_rd_wen, r_ebreak, r_invalid;
  logic [4:0]        r_rd_addr;

  logic [XLEN-1:0]   w_imm_i, w_imm_u, w_imm_j;
  logic [XLEN-1:0]   w_rs1_val, w_rs2_val;
  logic [OPC_W-1:0]  w_opcode;
  logic [XLEN-1:0]   w_op1, w_op2, w_op1_jump, w_op2_jump;
  logic              w_jump, w_rd_wen, w_ebreak, w_invalid, w_alu;
  logic              w_accept, w_drain;

  ysyx_22040237_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst  (in_inst[31:12]),
    .imm_i (w_imm_i),
    .imm_u (w_imm_u),
    .imm_j (w_imm_j)
  );

  assign rf_raddr1 = in_inst[19:15];
  assign rf_raddr2 = in_inst[24:20];
  assign w_rs1_val = (in_inst[19:15] == 5'd0) ? '0 : rf_rdata1;
  assign w_rs2_val = (in_inst[24:20] == 5'd0) ? '0 : rf_rdata2;

  assign in_ready = (r_state == S_RUN) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_out_valid && out_ready;

  always_comb begin
    w_opcode   = OPC_W'(INST_NOP);
    w_op1      = '0;
    w_op2      = '0;
    w_op1_jump = '0;
    w_op2_jump = '0;
    w_jump     = 1'b0;
    w_alu      = 1'b0;
    w_ebreak   = 1'b0;
    case (in_inst[6:0])
      OP_IMM: if (in_inst[14:12] == 3'd0) begin
        w_alu = 1'b1;
        w_op1 = w_rs1_val;
        w_op2 = w_imm_i;
      end
      OP: if (in_inst[14:12] == 3'd0 && in_inst[31:25] == 7'd0) begin
        w_alu = 1'b1;
        w_op1 = w_rs1_val;
        w_op2 = w_rs2_val;
      end
      LUI: begin
        w_alu = 1'b1;
        w_op2 = w_imm_u;
      end
      AUIPC: begin
        w_alu = 1'b1;
        w_op1 = in_pc;
        w_op2 = w_imm_u;
      end
      JAL: begin
        w_alu      = 1'b1;
        w_op1      = in_pc;
        w_op2      = XLEN'(4);
        w_op1_jump = in_pc;
        w_op2_jump = w_imm_j;
        w_jump     = 1'b1;
      end
      JALR: if (in_inst[14:12] == 3'd0) begin
        w_alu      = 1'b1;
        w_op1      = in_pc;
        w_op2      = XLEN'(4);
        w_op1_jump = w_rs1_val;
        w_op2_jump = w_imm_i;
        w_jump     = 1'b1;
      end
      SYSTEM: w_ebreak = (in_inst == EBREAK_WORD);
      default: ;
    endcase
    if (w_alu) w_opcode = OPC_W'(INST_ADD);
    w_rd_wen  = w_alu && (in_inst[11:7] != 5'd0);
    w_invalid = !w_alu && !w_ebreak;
  end

  // A terminating instruction stops fetch; HALT is only left through reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (w_accept && (w_ebreak || w_invalid)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drain) w_state_nxt = S_HALT;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_out_valid <= 1'b0;
      r_opcode    <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_op1_jump  <= '0;
      r_op2_jump  <= '0;
      r_jump      <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_wen    <= 1'b0;
      r_pc        <= '0;
      r_ebreak    <= 1'b0;
      r_invalid   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_opcode    <= w_opcode;
        r_op1       <= w_op1;
        r_op2       <= w_op2;
        r_op1_jump  <= w_op1_jump;
        r_op2_jump  <= w_op2_jump;
        r_jump      <= w_jump;
        r_rd_addr   <= in_inst[11:7];
        r_rd_wen    <= w_rd_wen;
        r_pc        <= in_pc;
        r_ebreak    <= w_ebreak;
        r_invalid   <= w_invalid;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign inst_opcode  = r_opcode;
  assign op1          = r_op1;
  assign op2          = r_op2;
  assign op1_jump     = r_op1_jump;
  assign op2_jump     = r_op2_jump;
  assign jump         = r_jump;
  assign rd_addr      = r_rd_addr;
  assign rd_wen       = r_rd_wen;
  assign out_pc       = r_pc;
  assign inst_ebreak  = r_ebreak && r_out_valid;
  assign invalid_inst = r_invalid && r_out_valid;
  assign halted       = (r_state == S_HALT);

`ifdef YSYX_22040237_IDU_PERF_EN
  logic [63:0] r_perf_issued, r_perf_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_drain) r_perf_issued <= r_perf_issued + 64'd1;
      if (r_out_valid && !out_ready) r_perf_stall <= r_perf_stall + 64'd1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040237_idu.sv
// ============================================================================
// Module      : tb_ysyx_22040237_idu
// Description : Scoreboard bench for the IDU with directed, hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22040237_idu;

  typedef struct packed {
    logic [7:0]  opc;
    logic [63:0] op1, op2, op1j, op2j;
    logic        jump;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] pc;
    logic        ebreak, invalid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [63:0] rf_rdata1 = '0, rf_rdata2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  inst_opcode;
  logic [63:0] op1, op2, op1_jump, op2_jump, out_pc;
  logic        jump, rd_wen, inst_ebreak, invalid_inst, halted;
  logic [4:0]  rd_addr;
`ifdef YSYX_22040237_IDU_PERF_EN
  logic [63:0] perf_issued, perf_stall;
`endif

  ysyx_22040237_idu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .out_valid(out_valid),
    .out_ready(out_ready), .inst_opcode(inst_opcode), .op1(op1), .op2(op2),
    .op1_jump(op1_jump), .op2_jump(op2_jump), .jump(jump), .rd_addr(rd_addr),
    .rd_wen(rd_wen), .out_pc(out_pc), .inst_ebreak(inst_ebreak),
    .invalid_inst(invalid_inst), .halted(halted)
`ifdef YSYX_22040237_IDU_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  int   n_pop = 0;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake pops and compares one expected bundle.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_pop++;
        chk("opcode",   64'(inst_opcode),  64'(e.opc));
        chk("op1",      op1,               e.op1);
        chk("op2",      op2,               e.op2);
        chk("op1_jump", op1_jump,          e.op1j);
        chk("op2_jump", op2_jump,          e.op2j);
        chk("jump",     64'(jump),         64'(e.jump));
        chk("rd_addr",  64'(rd_addr),      64'(e.rd));
        chk("rd_wen",   64'(rd_wen),       64'(e.wen));
        chk("out_pc",   out_pc,            e.pc);
        chk("ebreak",   64'(inst_ebreak),  64'(e.ebreak));
        chk("invalid",  64'(invalid_inst), 64'(e.invalid));
      end
    end
  end

  function automatic exp_t mk(input logic [7:0] opc, input logic [63:0] o1, o2, j1, j2,
                              input logic jmp, input logic [4:0] rd, input logic wen,
                              input logic [63:0] pc, input logic eb, inv);
    exp_t e;
    e = '{opc: opc, op1: o1, op2: o2, op1j: j1, op2j: j2, jump: jmp, rd: rd,
          wen: wen, pc: pc, ebreak: eb, invalid: inv};
    return e;
  endfunction

  task automatic issue(input logic [31:0] inst, input logic [63:0] pc, d1, d2,
                       input exp_t e, output int waits);
    bit ok = 0;
    in_valid = 1'b1; in_inst = inst; in_pc = pc; rf_rdata1 = d1; rf_rdata2 = d2;
    waits = 0;
    while (!ok && waits < 20) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        ok = 1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    sb.delete();
    #1 rst = 1'b1;
  endtask

  localparam logic [63:0] PC0 = 64'h8000_0000;
  localparam logic [63:0] PCJ = 64'h8000_0010;

  initial begin
    int w;
    int pops0;
    bit seen_ready;

    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_halted",    64'(halted),    64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_op1",       op1,            64'd0);
    chk("rst_opcode",    64'(inst_opcode), 64'd0);

    // Back-to-back issue with out_ready held high.
    out_ready = 1'b1;
    issue(32'h0050_0093, PC0, 64'h1111, 64'h2222,
          mk(8'h01, 0, 5, 0, 0, 0, 5'd1, 1, PC0, 0, 0), w);
    chk("b2b_wait0", 64'(w), 64'd0);
    issue(32'h0020_81B3, PC0 + 4, 64'd7, 64'd9,
          mk(8'h01, 7, 9, 0, 0, 0, 5'd3, 1, PC0 + 4, 0, 0), w);
    chk("b2b_wait1", 64'(w), 64'd0);
    issue(32'h0080_00EF, PCJ, 64'h5, 64'h6,
          mk(8'h01, PCJ, 4, PCJ, 8, 1, 5'd1, 1, PCJ, 0, 0), w);
    chk("b2b_wait2", 64'(w), 64'd0);
    issue(32'h1234_52B7, PCJ + 8, 64'h5, 64'h6,
          mk(8'h01, 0, 64'h1234_5000, 0, 0, 0, 5'd5, 1, PCJ + 8, 0, 0), w);
    chk("b2b_wait3", 64'(w), 64'd0);
    wait_drain();
    chk("b2b_pops", 64'(n_pop), 64'd4);
`ifdef YSYX_22040237_IDU_PERF_EN
    chk("perf_issued", perf_issued, 64'd4);
    chk("perf_stall",  perf_stall,  64'd0);
`endif

    // Backpressure: bundle held three cycles, popped once on release.
    out_ready = 1'b0;
    pops0 = n_pop;
    issue(32'h0020_81B3, PC0 + 64'h20, 64'd7, 64'd9,
          mk(8'h01, 7, 9, 0, 0, 0, 5'd3, 1, PC0 + 64'h20, 0, 0), w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_ready", 64'(in_ready),  64'd0);
      chk("hold_op1",   op1,            64'd7);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_pop_once", 64'(n_pop - pops0), 64'd1);
    chk("hold_cleared",  64'(out_valid),     64'd0);

    // Sign-extension and rd=x0 corner cases.
    issue(32'hFFF0_8113, PC0 + 64'h40, 64'd10, 64'd0,
          mk(8'h01, 10, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 5'd2, 1, PC0 + 64'h40, 0, 0), w);
    issue(32'h8000_0397, PC0 + 64'h44, 64'd0, 64'd0,
          mk(8'h01, PC0 + 64'h44, 64'hFFFF_FFFF_8000_0000, 0, 0, 0, 5'd7, 1, PC0 + 64'h44, 0, 0), w);
    issue(32'h0000_8067, PC0 + 64'h48, 64'h8000_0200, 64'd0,
          mk(8'h01, PC0 + 64'h48, 4, 64'h8000_0200, 0, 1, 5'd0, 0, PC0 + 64'h48, 0, 0), w);
    wait_drain();

    // ebreak held under backpressure, following addi must never be taken.
    out_ready = 1'b0;
    issue(32'h0010_0073, PC0 + 64'h60, 64'd0, 64'd0,
          mk(8'h00, 0, 0, 0, 0, 0, 5'd0, 0, PC0 + 64'h60, 1, 0), w);
    in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = PC0 + 64'h64;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("ebreak_held",  64'(inst_ebreak), 64'd1);
      chk("ebreak_stall", 64'(in_ready),    64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    seen_ready = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (in_ready) seen_ready = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("halt_no_accept", 64'(seen_ready),  64'd0);
    chk("halt_halted",    64'(halted),      64'd1);
    chk("halt_valid",     64'(out_valid),   64'd0);
    chk("halt_ebreak",    64'(inst_ebreak), 64'd0);
    chk("halt_queue",     64'(sb.size()),   64'd0);

    // Invalid instruction path, then reset recovery.
    do_reset();
    chk("rst2_halted",   64'(halted),   64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    issue(32'h0000_0000, PC0 + 64'h100, 64'd3, 64'd4,
          mk(8'h00, 0, 0, 0, 0, 0, 5'd0, 0, PC0 + 64'h100, 0, 1), w);
    wait_drain();
    @(posedge clk); #1;
    chk("inv_halted", 64'(halted),   64'd1);
    chk("inv_ready",  64'(in_ready), 64'd0);
    do_reset();
    chk("rst3_valid",    64'(out_valid), 64'd0);
    chk("rst3_halted",   64'(halted),    64'd0);
    chk("rst3_in_ready", 64'(in_ready),  64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
